// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: decoded pixel, frame and error pulses from the WS2812 receiver
interface ws2812_rx_if;
   logic        pixel_vld_out;
   logic [5:0]  pixel_addr_out;
   logic [23:0] pixel_data_out;
   logic        frame_done_out;
   logic        err_out;
   modport master (output pixel_vld_out, pixel_addr_out, pixel_data_out, frame_done_out, err_out);
   modport slave (input pixel_vld_out, pixel_addr_out, pixel_data_out, frame_done_out, err_out);
endinterface

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 serial stream into indexed 24-bit GRB pixels
module ws2812_rx #(
   parameter int CNT_MIN_H = 2*25,
   parameter int CNT_T1_H  = 2*60,
   parameter int CNT_MAX_H = 2*500,
   parameter int CNT_RST   = 2*5000
) (
   input logic        clk_in,
   input logic        rst_n_in,
   input logic        din_in,
   ws2812_rx_if.master px
);
   localparam logic [1:0] STA_SYNC = 2'd0, STA_IDLE = 2'd1, STA_HIGH = 2'd2, STA_LOW = 2'd3;
   logic [1:0]  st;
   logic        s1, s2, s3;
   logic [15:0] cnt;
   logic [4:0]  bcnt;
   logic [6:0]  idx;
   logic [23:0] sh;
   logic        rise, fall, bit_v;
   logic [23:0] sh_n;
   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;
   assign bit_v = cnt >= 16'(CNT_T1_H);
   assign sh_n  = {sh[22:0], bit_v};
   // idx runs 0..64 for stored pixels; 65 marks an already-reported overflow
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         st <= STA_SYNC;
         {s1, s2, s3} <= '0;
         cnt <= '0;
         bcnt <= '0;
         idx <= '0;
         sh <= '0;
         px.pixel_vld_out <= 1'b0;
         px.pixel_addr_out <= '0;
         px.pixel_data_out <= '0;
         px.frame_done_out <= 1'b0;
         px.err_out <= 1'b0;
      end else begin
         s1 <= din_in;
         s2 <= s1;
         s3 <= s2;
         cnt <= (rise || fall || (st == STA_SYNC && s2)) ? '0 : cnt + 16'(cnt != 16'hFFFF);
         px.pixel_vld_out <= 1'b0;
         px.frame_done_out <= 1'b0;
         px.err_out <= 1'b0;
         case (st)
            STA_SYNC: if (!s2 && cnt == 16'(CNT_RST)) st <= STA_IDLE;
            STA_IDLE: if (rise) st <= STA_HIGH;
            STA_HIGH: begin
               if ((fall && cnt < 16'(CNT_MIN_H)) || (!fall && cnt >= 16'(CNT_MAX_H))) begin
                  px.err_out <= 1'b1;
                  bcnt <= '0;
                  idx <= '0;
                  st <= STA_SYNC;
               end else if (fall) begin
                  st <= STA_LOW;
                  sh <= sh_n;
                  bcnt <= (bcnt == 5'd23) ? '0 : bcnt + 5'd1;
                  if (bcnt == 5'd23) begin
                     if (idx < 7'd64) begin
                        px.pixel_vld_out <= 1'b1;
                        px.pixel_addr_out <= idx[5:0];
                        px.pixel_data_out <= sh_n;
                     end
                     px.err_out <= idx == 7'd64;
                     idx <= (idx == 7'd65) ? idx : idx + 7'd1;
                  end
               end
            end
            STA_LOW: begin
               if (rise) st <= STA_HIGH;
               else if (cnt == 16'(CNT_RST)) begin
                  st <= STA_IDLE;
                  px.frame_done_out <= idx != 7'd0;
                  px.err_out <= bcnt != 5'd0;
                  idx <= '0;
                  bcnt <= '0;
               end
            end
            default: st <= STA_SYNC;
         endcase
      end
   end
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed frames on a time-scaled receiver, scoreboard of expected pulses
module tb_ws2812_rx;
   localparam int MIN_H = 5, T1_H = 12, MAX_H = 100, RST = 1000, GAP = 1200;
   logic clk_in = 1'b0, rst_n_in = 1'b0, din_in = 1'b0;
   ws2812_rx_if px ();
   ws2812_rx #(.CNT_MIN_H(MIN_H), .CNT_T1_H(T1_H), .CNT_MAX_H(MAX_H), .CNT_RST(RST)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .din_in(din_in), .px(px));
   always #5 clk_in = ~clk_in;
   typedef struct packed {logic [1:0] kind; logic [5:0] addr; logic [23:0] data;} ev_t;
   ev_t exp_q[$];
   int total = 0, bad = 0, nxt_addr = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask
   // kinds: 0 pixel, 1 frame_done, 2 err
   task automatic take(input logic [1:0] k, input logic [5:0] a, input logic [23:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: got kind %0d addr %0d data %06h, want none", k, a, d);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", 32'(k), 32'(e.kind));
         if (k == 2'd0 && e.kind == 2'd0) begin
            chk("pixel_addr", 32'(a), 32'(e.addr));
            chk("pixel_data", 32'(d), 32'(e.data));
         end
      end
   endtask
   always @(negedge clk_in) if (rst_n_in) begin
      if (px.pixel_vld_out) take(2'd0, px.pixel_addr_out, px.pixel_data_out);
      if (px.frame_done_out) take(2'd1, 6'd0, 24'd0);
      if (px.err_out) take(2'd2, 6'd0, 24'd0);
   end
   task automatic push(input logic [1:0] k, input logic [5:0] a, input logic [23:0] d);
      exp_q.push_back(ev_t'{k, a, d});
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk_in);
   endtask
   task automatic send_bit(input logic b);
      din_in = 1'b1;
      cyc(b ? 16 : 8);
      din_in = 1'b0;
      cyc(b ? 9 : 17);
   endtask
   task automatic send_px(input logic [23:0] d);
      for (int i = 23; i >= 0; i--) send_bit(d[i]);
   endtask
   task automatic pixel(input logic [23:0] d);
      push(2'd0, nxt_addr[5:0], d);
      nxt_addr++;
      send_px(d);
   endtask
   task automatic end_frame();
      push(2'd1, 6'd0, 24'd0);
      din_in = 1'b0;
      cyc(GAP);
      nxt_addr = 0;
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_vld"}, 32'(px.pixel_vld_out), 32'd0);
      chk({tag, "_addr"}, 32'(px.pixel_addr_out), 32'd0);
      chk({tag, "_data"}, 32'(px.pixel_data_out), 32'd0);
      chk({tag, "_fd"}, 32'(px.frame_done_out), 32'd0);
      chk({tag, "_err"}, 32'(px.err_out), 32'd0);
   endtask
   initial begin
      logic [7:0] p8;
      cyc(3);
      chk_zero("reset");
      rst_n_in = 1'b1;
      cyc(GAP);
      // three-pixel frame
      pixel(24'hFF0000);
      pixel(24'h00FF00);
      pixel(24'h0000AA);
      end_frame();
      // 12 bits then a frame gap: partial pixel error, no frame_done
      push(2'd2, 6'd0, 24'd0);
      for (int i = 0; i < 12; i++) send_bit(i[0]);
      din_in = 1'b0;
      cyc(GAP);
      // short glitch mid-pixel; the following pixel is ignored until a full gap
      push(2'd2, 6'd0, 24'd0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      din_in = 1'b1;
      cyc(2);
      din_in = 1'b0;
      cyc(9);
      send_px(24'hFFFFFF);
      din_in = 1'b0;
      cyc(GAP);
      pixel(24'h112233);
      pixel(24'h445566);
      end_frame();
      // over-long high pulse, then two pixels split by a legal mid-length low
      push(2'd2, 6'd0, 24'd0);
      din_in = 1'b1;
      cyc(200);
      din_in = 1'b0;
      cyc(GAP);
      pixel(24'h123456);
      din_in = 1'b0;
      cyc(600);
      pixel(24'h654321);
      end_frame();
      // reset after 10 bits clears outputs at once; decoding needs a fresh gap
      for (int i = 0; i < 10; i++) send_bit(1'b1);
      rst_n_in = 1'b0;
      #1;
      chk_zero("midrst");
      cyc(3);
      rst_n_in = 1'b1;
      send_px(24'hC0FFEE);
      din_in = 1'b0;
      cyc(GAP);
      pixel(24'h5A5A5A);
      end_frame();
      // 66 pixels: 64 stored, one overflow error, one frame_done
      for (int p = 0; p < 66; p++) begin
         p8 = 8'(p);
         if (p < 64) push(2'd0, p8[5:0], {p8, ~p8, p8 ^ 8'h3C});
         if (p == 64) push(2'd2, 6'd0, 24'd0);
         send_px({p8, ~p8, p8 ^ 8'h3C});
      end
      end_frame();
      cyc(20);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         $display("FAIL missing_event: got none want kind %0d addr %0d data %06h", e.kind, e.addr, e.data);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 CNT_MIN_H, 2*25, shortest legal high pulse in clk cycles (0.25 us at 200 MHz); shorter is a glitch error.
REQ-002 CNT_T1_H, 2*60, high-time threshold; high count >= CNT_T1_H decodes '1', otherwise '0'.
REQ-003 CNT_MAX_H, 2*500, longest legal high pulse (5 us); reaching it is an error.
REQ-004 CNT_RST, 2*5000, low time (50 us) that marks a frame boundary.
REQ-005 clk_in  in  1  system clock; one clock only.
REQ-006 rst_n_in  in  1  reset, asynchronous, active-low.
REQ-007 din_in  in  1  WS2812 serial line, asynchronous to clk_in.
REQ-008 pixel_vld_out  out  1  one-cycle pulse: pixel_addr_out/pixel_data_out valid.
REQ-009 pixel_addr_out  out  6  pixel index within the frame, 0..63.
REQ-010 pixel_data_out  out  24  received pixel, first bit received in bit 23 (GRB order).
REQ-011 frame_done_out  out  1  one-cycle pulse at the end of a frame that contained at least one complete pixel.
REQ-012 err_out  out  1  one-cycle pulse on any protocol error.

Function
REQ-013 Pass din_in through a 2-flop synchronizer, then a history flop; detect rise and fall edges on the synchronized signal only.
REQ-014 FSM states: STA_SYNC (wait for low >= CNT_RST), STA_IDLE (frame boundary seen, wait for rise), STA_HIGH (count high time), STA_LOW (count low time).
REQ-015 Use one 16-bit counter, saturating at 16'hFFFF; clear it to 0 on every detected edge.
REQ-016 STA_SYNC: count while the line is low and clear on high; at count == CNT_RST go to STA_IDLE with no output pulse.
REQ-017 STA_IDLE or STA_LOW plus a rise: go to STA_HIGH.
REQ-018 STA_HIGH plus a fall with count < CNT_MIN_H: err_out pulse, discard the partial pixel, go to STA_SYNC.
REQ-019 STA_HIGH plus a fall otherwise: shift the decoded bit into the 24-bit shift register (MSB first), increment the 5-bit bit count, go to STA_LOW.
REQ-020 STA_HIGH with count reaching CNT_MAX_H before a fall: err_out pulse, discard the partial pixel, go to STA_SYNC.
REQ-021 The 24th bit completes a pixel: pixel_vld_out=1 for one cycle, pixel_data_out=shift value, pixel_addr_out=current index, bit count reset to 0, index incremented.
REQ-022 Output latency: pixel_vld_out is high in the cycle after the 3rd rising clk_in edge counted from the edge that first samples din_in low.
REQ-023 Index 63 is the last stored pixel; complete pixels beyond 64 produce no pixel_vld_out, raise one err_out pulse (first overflow only), and decoding continues.
REQ-024 STA_LOW with count == CNT_RST: go to STA_IDLE; reset the index to 0.
REQ-025 At that CNT_RST point, frame_done_out pulses if the index was > 0.
REQ-026 At that CNT_RST point, if the bit count is nonzero, also pulse err_out and discard the partial pixel.
REQ-027 A low gap between CNT_MAX_H and CNT_RST is legal: decoding continues, no error.
REQ-028 frame_done_out and err_out may pulse in the same cycle; pixel_vld_out never coincides with frame_done_out.
REQ-029 pixel_addr_out and pixel_data_out hold their values between pulses.

Reset
REQ-030 On rst_n_in low: state=STA_SYNC; counter, bit count, index and shift register =0; all outputs =0; synchronizer flops =0.
REQ-031 Reset asserted mid-frame abandons the frame with no pulses; after release, a CNT_RST low gap is required before any decoding.

Verification
REQ-032 Low 60 us, then 3 pixels 0xFF0000/0x00FF00/0x0000AA (T0H 0.4 us, T1H 0.8 us, 1.25 us period), then low 60 us -> pixel_vld_out at addr 0,1,2 with those data; one frame_done_out; no err_out.
REQ-033 Low 60 us, then 66 pixels, then low -> exactly 64 pixel_vld_out (addr 0..63), one err_out, one frame_done_out.
REQ-034 Low 60 us, then 12 bits, then low 60 us -> no pixel_vld_out, err_out=1 once, no frame_done_out.
REQ-035 A 50 ns high glitch inside a pixel -> err_out; decoding resumes only after a 50 us low; the next full frame decodes correctly from addr 0.
REQ-036 A 10 us high pulse -> err_out at count CNT_MAX_H; a 30 us low between two pixels -> both pixels decode with no error or frame_done_out.
REQ-037 rst_n_in pulsed low after 10 bits -> all outputs 0 immediately; the following frame decodes from addr 0.
